// File: rtl/hex7seg_scan.sv
// Multiplexed 7-segment scanner with double-buffered display data and frame-aligned commit.
// Optional build macro HEX7SEG_LZB_EN enables leading-zero blanking.
module hex7seg_scan #(
    parameter int NDIGITS = 8,
    parameter int DIV     = 50000,
    parameter int GUARD   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5*NDIGITS-1:0]   data_in,
    input  logic [NDIGITS-1:0]     dp_in,
    input  logic                   load,
    output logic                   load_ack,
    output logic [NDIGITS-1:0]     an,
    output logic [6:0]             a2g,
    output logic                   dp,
    output logic                   frame_done
);

    localparam int              PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int              IW         = $clog2(NDIGITS);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);
    localparam logic [IW-1:0]   IDX_LAST   = IW'(NDIGITS - 1);
    localparam logic [PW-1:0]   GUARD_END  = PW'(GUARD);
    localparam logic [4:0]      CODE_BLANK = 5'd31;

    logic [PW-1:0]          presc_q, presc_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   pending_q, pending_d;
    logic [5*NDIGITS-1:0]   stage_code_q, stage_code_d;
    logic [NDIGITS-1:0]     stage_dp_q, stage_dp_d;
    logic [5*NDIGITS-1:0]   shadow_code_q, shadow_code_d;
    logic [NDIGITS-1:0]     shadow_dp_q, shadow_dp_d;
    logic [NDIGITS-1:0]     an_q, an_d;
    logic [6:0]             a2g_q, a2g_d;
    logic                   dp_q, dp_d;
    logic                   frame_done_q, frame_done_d;
    logic                   load_ack_q, load_ack_d;

    logic                   slot_wrap;
    logic                   frame_wrap;
    logic                   in_guard;
    logic [4:0]             cur_code;
    logic                   cur_dp;
    logic                   cur_blank;
    logic [NDIGITS-1:0]     lz_blank;
`ifdef HEX7SEG_LZB_EN
    logic                   lz_run;
`endif

    function automatic logic [6:0] seg_decode(input logic [4:0] code);
        logic [6:0] seg;
        case (code)
            5'd0:    seg = 7'b1000000;
            5'd1:    seg = 7'b1111001;
            5'd2:    seg = 7'b0100100;
            5'd3:    seg = 7'b0110000;
            5'd4:    seg = 7'b0011001;
            5'd5:    seg = 7'b0010010;
            5'd6:    seg = 7'b0000010;
            5'd7:    seg = 7'b1111000;
            5'd8:    seg = 7'b0000000;
            5'd9:    seg = 7'b0010000;
            5'd10:   seg = 7'b0001000;
            5'd11:   seg = 7'b0000011;
            5'd12:   seg = 7'b1000110;
            5'd13:   seg = 7'b0100001;
            5'd14:   seg = 7'b0000110;
            5'd15:   seg = 7'b0001110;
            5'd16:   seg = 7'b0110111;
            5'd17:   seg = 7'b0111001;
            5'd18:   seg = 7'b0111111;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    always_comb begin
        slot_wrap  = (presc_q == PRESC_LAST);
        frame_wrap = slot_wrap && (idx_q == IDX_LAST);
        in_guard   = (presc_q < GUARD_END);

        presc_d = slot_wrap ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (slot_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // Commit uses pre-edge staging; a coincident load refills staging and keeps pending set.
        stage_code_d  = stage_code_q;
        stage_dp_d    = stage_dp_q;
        shadow_code_d = shadow_code_q;
        shadow_dp_d   = shadow_dp_q;
        pending_d     = pending_q;
        load_ack_d    = 1'b0;
        if (frame_wrap && pending_q) begin
            shadow_code_d = stage_code_q;
            shadow_dp_d   = stage_dp_q;
            pending_d     = 1'b0;
            load_ack_d    = 1'b1;
        end
        if (load) begin
            stage_code_d = data_in;
            stage_dp_d   = dp_in;
            pending_d    = 1'b1;
        end
        frame_done_d = frame_wrap;

        lz_blank = '0;
`ifdef HEX7SEG_LZB_EN
        lz_run = 1'b1;
        for (int i = NDIGITS - 1; i >= 1; i--) begin
            lz_run      = lz_run && (shadow_code_q[5*i +: 5] == 5'd0);
            lz_blank[i] = lz_run;
        end
`endif

        cur_code  = CODE_BLANK;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_code  = shadow_code_q[5*i +: 5];
                cur_dp    = shadow_dp_q[i];
                cur_blank = lz_blank[i];
            end
        end

        for (int i = 0; i < NDIGITS; i++) begin
            an_d[i] = in_guard || (idx_q != IW'(i));
        end
        a2g_d = (in_guard || cur_blank) ? 7'b1111111 : seg_decode(cur_code);
        dp_d  = in_guard || !cur_dp;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q       <= '0;
            idx_q         <= '0;
            pending_q     <= 1'b0;
            stage_code_q  <= {NDIGITS{CODE_BLANK}};
            stage_dp_q    <= '0;
            shadow_code_q <= {NDIGITS{CODE_BLANK}};
            shadow_dp_q   <= '0;
            an_q          <= '1;
            a2g_q         <= 7'b1111111;
            dp_q          <= 1'b1;
            frame_done_q  <= 1'b0;
            load_ack_q    <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            pending_q     <= pending_d;
            stage_code_q  <= stage_code_d;
            stage_dp_q    <= stage_dp_d;
            shadow_code_q <= shadow_code_d;
            shadow_dp_q   <= shadow_dp_d;
            an_q          <= an_d;
            a2g_q         <= a2g_d;
            dp_q          <= dp_d;
            frame_done_q  <= frame_done_d;
            load_ack_q    <= load_ack_d;
        end
    end

    assign an         = an_q;
    assign a2g        = a2g_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;
    assign load_ack   = load_ack_q;

endmodule

// File: tb/tb_hex7seg_scan.sv
// Scoreboard bench for hex7seg_scan (NDIGITS=4, DIV=8, GUARD=2).
// Honours HEX7SEG_LZB_EN when choosing expected leading-zero segments.
module tb_hex7seg_scan;

    localparam int ND = 4;
    localparam int DV = 8;
    localparam int GD = 2;

    localparam logic [6:0] S_BL    = 7'b1111111;
    localparam logic [6:0] S_0     = 7'b1000000;
    localparam logic [6:0] S_1     = 7'b1111001;
    localparam logic [6:0] S_5     = 7'b0010010;
    localparam logic [6:0] S_7     = 7'b1111000;
    localparam logic [6:0] S_8     = 7'b0000000;
    localparam logic [6:0] S_9     = 7'b0010000;
    localparam logic [6:0] S_A     = 7'b0001000;
    localparam logic [6:0] S_C     = 7'b1000110;
    localparam logic [6:0] S_D     = 7'b0100001;
    localparam logic [6:0] S_E     = 7'b0000110;
    localparam logic [6:0] S_F     = 7'b0001110;
    localparam logic [6:0] S_EQ    = 7'b0110111;
    localparam logic [6:0] S_PLUS  = 7'b0111001;
    localparam logic [6:0] S_MINUS = 7'b0111111;
`ifdef HEX7SEG_LZB_EN
    localparam logic [6:0] S_LZ    = S_BL;
`else
    localparam logic [6:0] S_LZ    = S_0;
`endif

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } disp_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           load = 1'b0;
    logic [19:0]    data_in = '0;
    logic [3:0]     dp_in = '0;
    logic           load_ack;
    logic [3:0]     an;
    logic [6:0]     a2g;
    logic           dp;
    logic           frame_done;

    int     checks = 0;
    int     errors = 0;
    int     fnum = 0;
    disp_t  dq[$];
    int     aq[$];

    always #5 clk = ~clk;

    hex7seg_scan #(.NDIGITS(ND), .DIV(DV), .GUARD(GD)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .load       (load),
        .load_ack   (load_ack),
        .an         (an),
        .a2g        (a2g),
        .dp         (dp),
        .frame_done (frame_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 32-cycle frame: queue the expected display for this frame, then drive loads at given cycles.
    task automatic do_frame(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                            input logic [6:0] s0, input logic [3:0] dpx,
                            input int l1c, input logic [19:0] l1d, input logic [3:0] l1p,
                            input int l2c, input logic [19:0] l2d, input logic [3:0] l2p,
                            input bit ack, input int stop_at);
        logic [6:0] segs[4];
        disp_t      e;
        segs = '{s0, s1, s2, s3};
        for (int i = 0; i < 4; i++) begin
            e.an  = ~(4'b0001 << i);
            e.seg = segs[i];
            e.dp  = ~dpx[i];
            dq.push_back(e);
        end
        if (ack) aq.push_back(fnum + 1);
        for (int c = 1; c <= 32; c++) begin
            if (c == stop_at) return;
            load = 1'b0;
            if (c == l1c) begin
                load = 1'b1; data_in = l1d; dp_in = l1p;
            end
            if (c == l2c) begin
                load = 1'b1; data_in = l2d; dp_in = l2p;
            end
            tick();
        end
        load = 1'b0;
        fnum++;
    endtask

    task automatic do_reset(input bit with_load, input logic [19:0] d);
        reset   = 1'b1;
        load    = with_load;
        data_in = d;
        dp_in   = 4'hF;
        tick();
        load = 1'b0;
        tick();
        reset = 1'b0;
        fnum  = 0;
    endtask

    // Monitor: samples on the falling edge, consumes scoreboard entries as the DUT presents them.
    initial begin
        logic  r;
        logic  prev_r;
        bit    active;
        int    low_cnt;
        int    gap;
        int    fcount;
        int    exp_f;
        disp_t cur;
        prev_r = 1'b0; active = 0; low_cnt = 0; gap = 0; fcount = 0;
        cur = '0;
        forever begin
            @(posedge clk);
            r = reset;
            @(negedge clk);
            if (r) begin
                chk("rst_an", 32'(an), 32'hF);
                chk("rst_a2g", 32'(a2g), 32'h7F);
                chk("rst_dp", 32'(dp), 32'h1);
                chk("rst_ack", 32'(load_ack), 32'h0);
                chk("rst_frame_done", 32'(frame_done), 32'h0);
                if (!prev_r) dq.delete();
                gap = 0; fcount = 0; active = 0;
            end else begin
                gap++;
                chk("frame_done_timing", 32'(frame_done), 32'(gap == 32));
                if (frame_done) fcount++;
                if (gap == 32) gap = 0;
                if (load_ack) begin
                    if (aq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_load_ack: got 1 expected 0 (frame %0d)", fcount);
                    end else begin
                        exp_f = aq.pop_front();
                        chk("load_ack_frame", 32'(fcount), 32'(exp_f));
                    end
                end
                if (an != 4'hF) begin
                    if (!active) begin
                        if (dq.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_digit: got an=%0h expected no slot", an);
                            cur = '{an: an, seg: a2g, dp: dp};
                        end else begin
                            cur = dq.pop_front();
                        end
                        active  = 1;
                        low_cnt = 0;
                    end
                    low_cnt++;
                    chk("an", 32'(an), 32'(cur.an));
                    chk("a2g", 32'(a2g), 32'(cur.seg));
                    chk("dp", 32'(dp), 32'(cur.dp));
                end else begin
                    chk("guard_dp", 32'(dp), 32'h1);
                    if (active) begin
                        chk("enable_low_cycles", 32'(low_cnt), 32'd6);
                        active = 0;
                    end
                end
            end
            prev_r = r;
        end
    end

    initial begin
        do_reset(1'b0, '0);
        // idle blank frames, then a mid-frame load
        do_frame(S_BL, S_BL, S_BL, S_BL, 4'b0000, 0, '0, '0, 0, '0, '0, 0, 0);
        do_frame(S_BL, S_BL, S_BL, S_BL, 4'b0000,
                 10, {5'd18, 5'd16, 5'd10, 5'd1}, 4'b0000, 0, '0, '0, 1, 0);
        // two loads in one frame: last wins
        do_frame(S_MINUS, S_EQ, S_A, S_1, 4'b0000,
                 5, {5'd2, 5'd3, 5'd4, 5'd5}, 4'b1111,
                 20, {5'd8, 5'd9, 5'd12, 5'd13}, 4'b0100, 1, 0);
        // load at cycle 10, then one coincident with the frame wrap
        do_frame(S_8, S_9, S_C, S_D, 4'b0100,
                 10, {5'd14, 5'd15, 5'd17, 5'd19}, 4'b0001,
                 32, {5'd0, 5'd0, 5'd0, 5'd5}, 4'b0000, 1, 0);
        do_frame(S_E, S_F, S_PLUS, S_BL, 4'b0001, 0, '0, '0, 0, '0, '0, 1, 0);
        do_frame(S_LZ, S_LZ, S_LZ, S_5, 4'b0000,
                 12, {5'd0, 5'd7, 5'd0, 5'd0}, 4'b1000, 0, '0, '0, 1, 0);
        // pending load discarded by a mid-frame reset carrying its own (ignored) load
        do_frame(S_LZ, S_7, S_0, S_0, 4'b1000,
                 8, {5'd3, 5'd3, 5'd3, 5'd3}, 4'b0000, 0, '0, '0, 0, 20);
        do_reset(1'b1, {5'd1, 5'd1, 5'd1, 5'd1});
        do_frame(S_BL, S_BL, S_BL, S_BL, 4'b0000, 0, '0, '0, 0, '0, '0, 0, 0);
        do_frame(S_BL, S_BL, S_BL, S_BL, 4'b0000, 0, '0, '0, 0, '0, '0, 0, 0);
        tick();
        tick();
        chk("display_queue_drained", 32'(dq.size()), 32'd0);
        chk("ack_queue_drained", 32'(aq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
